// File: rtl/countdown_display.sv
// countdown_display: binary countdown to two BCD digits via double-dabble,
// shown on a 2-digit multiplexed seven-segment display with blanking.
module countdown_display #(
    parameter int W           = 8,
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_TH    = 3,
    parameter int BLINK_DIV   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] timer_value,
    input  logic [1:0]   light,
    output logic [6:0]   seg,
    output logic [1:0]   an,
    output logic         busy,
    output logic         fault
);

    localparam int CW = $clog2(W + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            start;
    logic            finish;
    logic [CW-1:0]   cnt;
    logic [W+7:0]    sr;
    logic [W+7:0]    adj;
    logic [W-1:0]    last_val;
    logic            pending;
    logic [W-1:0]    sat;
    logic [3:0]      tens;
    logic [3:0]      ones;
    logic [RW-1:0]   rcnt;
    logic            digit_sel;
    logic [BW-1:0]   bcnt;
    logic            blink_phase;
    logic [6:0]      shown;
    logic            blank_blink;
    logic [6:0]      seg_nx;
    logic [1:0]      an_nx;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Conversion FSM next state: start on a new value, W shifts, one commit.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (timer_value != last_val || pending) begin
                    start    = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(W - 1)) state_nx = DONE;
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Double-dabble step: add 3 to BCD nibbles >= 5 before each shift.
    always_comb begin
        sat = (timer_value > W'(99)) ? W'(99) : timer_value;
        adj = sr;
        if (sr[W+3:W] >= 4'd5)
            adj[W+3:W] = sr[W+3:W] + 4'd3;
        if (sr[W+7:W+4] >= 4'd5)
            adj[W+7:W+4] = sr[W+7:W+4] + 4'd3;
    end

    // Conversion datapath: capture, shift, commit digits, busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sr       <= '0;
            last_val <= '0;
            pending  <= 1'b1;
            tens     <= 4'd0;
            ones     <= 4'd0;
            busy     <= 1'b0;
        end else begin
            if (start) begin
                last_val <= timer_value;
                pending  <= 1'b0;
                sr       <= {8'h00, sat};
                cnt      <= '0;
                busy     <= 1'b1;
            end else if (state == SHIFT) begin
                sr  <= adj << 1;
                cnt <= cnt + 1'b1;
            end else if (finish) begin
                tens <= sr[W+7:W+4];
                ones <= sr[W+3:W];
                busy <= 1'b0;
            end
        end
    end

    // Free-running refresh and blink timebases.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt        <= '0;
            digit_sel   <= 1'b0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt      <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Display select: fault, blink and leading-zero blanking in priority.
    always_comb begin
        shown       = {3'b000, tens} * 7'd10 + {3'b000, ones};
        blank_blink = (shown <= 7'(BLINK_TH)) && blink_phase;
        an_nx       = 2'b11;
        seg_nx      = 7'h00;
        if (light == 2'b11 || blank_blink) begin
            an_nx  = 2'b11;
            seg_nx = 7'h00;
        end else if (digit_sel) begin
            if (tens != 4'd0) begin
                an_nx  = 2'b01;
                seg_nx = enc(tens);
            end
        end else begin
            an_nx  = 2'b10;
            seg_nx = enc(ones);
        end
    end

    // Registered display and fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= 7'h00;
            an    <= 2'b11;
            fault <= 1'b0;
        end else begin
            seg   <= seg_nx;
            an    <= an_nx;
            fault <= (light == 2'b11);
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// tb_countdown_display: directed plus random stimulus against an
// arithmetic reference model of the countdown display.
module tb_countdown_display;

    localparam int W  = 8;
    localparam int RD = 4;
    localparam int TH = 3;
    localparam int BD = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] timer_value;
    logic [1:0]   light;
    logic [6:0]   seg;
    logic [1:0]   an;
    logic         busy;
    logic         fault;

    int vectors;
    int miscompares;

    int         m_n;
    int         m_last;
    bit         m_pend;
    int         m_r;
    int         m_cv;
    int         m_tens;
    int         m_ones;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_busy;
    logic       e_fault;

    logic [6:0] lut [10];

    countdown_display #(
        .W(W),
        .REFRESH_DIV(RD),
        .BLINK_TH(TH),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .timer_value(timer_value),
        .light(light),
        .seg(seg),
        .an(an),
        .busy(busy),
        .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_last  = 0;
        m_pend  = 1'b1;
        m_r     = 0;
        m_cv    = 0;
        m_tens  = 0;
        m_ones  = 0;
        e_seg   = 7'h00;
        e_an    = 2'b11;
        e_busy  = 1'b0;
        e_fault = 1'b0;
    endtask

    task automatic model_step(input logic r, input int tv,
                              input logic [1:0] lt);
        int  ds;
        int  bp;
        int  val;
        if (r) begin
            model_reset();
            return;
        end
        ds  = (m_n / RD) % 2;
        bp  = (m_n / BD) % 2;
        val = 10 * m_tens + m_ones;
        if (lt == 2'b11 || (val <= TH && bp == 1) ||
            (ds == 1 && m_tens == 0)) begin
            e_an  = 2'b11;
            e_seg = 7'h00;
        end else if (ds == 1) begin
            e_an  = 2'b01;
            e_seg = lut[m_tens];
        end else begin
            e_an  = 2'b10;
            e_seg = lut[m_ones];
        end
        e_fault = (lt == 2'b11);
        if (m_r == 0) begin
            if (tv != m_last || m_pend) begin
                m_last = tv;
                m_pend = 1'b0;
                m_cv   = (tv > 99) ? 99 : tv;
                m_r    = W + 1;
            end
        end else begin
            m_r--;
            if (m_r == 0) begin
                m_tens = m_cv / 10;
                m_ones = m_cv % 10;
            end
        end
        e_busy = (m_r != 0);
        m_n++;
    endtask

    task automatic cyc(input logic r, input int tv, input logic [1:0] lt);
        rst         = r;
        timer_value = W'(tv);
        light       = lt;
        @(posedge clk);
        model_step(r, tv, lt);
        @(negedge clk);
        check("seg", {9'd0, seg}, {9'd0, e_seg});
        check("an", {14'd0, an}, {14'd0, e_an});
        check("busy", {15'd0, busy}, {15'd0, e_busy});
        check("fault", {15'd0, fault}, {15'd0, e_fault});
    endtask

    task automatic run(input int n, input int tv, input logic [1:0] lt);
        for (int i = 0; i < n; i++) cyc(1'b0, tv, lt);
    endtask

    initial begin
        int tv;
        logic [1:0] lt;
        logic r;
        lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
        lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
        lut[8] = 7'h7F; lut[9] = 7'h6F;
        vectors     = 0;
        miscompares = 0;
        model_reset();

        cyc(1'b1, 25, 2'b00);
        cyc(1'b1, 25, 2'b00);
        run(24, 25, 2'b00);

        cyc(1'b1, 0, 2'b00);
        run(14, 0, 2'b00);

        run(20, 7, 2'b00);
        run(20, 150, 2'b00);
        run(16, 100, 2'b00);
        run(40, 2, 2'b00);
        run(40, 4, 2'b00);

        cyc(1'b0, 25, 2'b00);
        run(30, 40, 2'b00);

        run(3, 40, 2'b11);
        run(5, 40, 2'b01);

        run(3, 60, 2'b10);
        cyc(1'b1, 60, 2'b10);
        run(15, 60, 2'b10);

        tv = 25;
        lt = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                if ($urandom_range(1, 0) == 0) tv = $urandom_range(12, 0);
                else                           tv = $urandom_range(255, 0);
            end
            if ($urandom_range(29, 0) == 0) lt = 2'($urandom_range(3, 0));
            r = ($urandom_range(299, 0) == 0);
            cyc(r, tv, lt);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
